// File: rtl/datamem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : datamem_responder                                             |
// | Description: Multi-cycle word data memory with req/ack handshake, wait     |
// |              states and illegal-address error. Optional per-lane stores    |
// |              when DATAMEM_BYTE_EN is defined.                              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module datamem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int         c_depth     = 1 << ADDR_WIDTH;
  localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_next_state;
  logic [3:0]  r_cnt, w_next_cnt;
  logic        w_accept, w_perform;

  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  logic        w_op_we;
  logic [31:0] w_op_addr, w_op_wdata;
  logic [3:0]  w_op_be;
  logic        w_legal, w_wr;
  logic [ADDR_WIDTH-1:0] w_idx;

  logic [31:0] r_mem [0:c_depth-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_perform    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next_state = S_RESP;
            w_perform    = 1'b1;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = c_wait_load;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
          w_perform    = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so it uses the live inputs.
  assign w_op_we    = (r_state == S_IDLE) ? we    : r_we;
  assign w_op_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_op_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_op_be    = (r_state == S_IDLE) ? be    : r_be;

  assign w_legal = (w_op_addr[1:0] == 2'b00) && ((w_op_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_idx   = w_op_addr[ADDR_WIDTH+1:2];
  assign w_wr    = w_perform && w_op_we && w_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_be    <= be;
      end
      ack  <= w_perform;
      err  <= w_perform && !w_legal;
      busy <= (w_next_state != S_IDLE);
      if (w_perform) begin
        rdata <= (!w_op_we && w_legal) ? r_mem[w_idx] : 32'd0;
      end
    end
  end

  // Gated on reset so a store landing on an edge held in reset is discarded.
`ifdef DATAMEM_BYTE_EN
  always_ff @(posedge clk) begin
    if (reset && w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_op_be[i]) r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
      end
    end
  end
`else
  logic w_unused_be;
  assign w_unused_be = ^w_op_be;

  always_ff @(posedge clk) begin
    if (reset && w_wr) r_mem[w_idx] <= w_op_wdata;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_datamem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_datamem_responder                                          |
// | Description: Table vectors, corner sequences and randomized traffic       |
// |              against a word-array reference model.                         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_datamem_responder;
  localparam int AW    = 10;
  localparam int WAITS = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [3:0]  be0 = 4'hF;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mm [int];

  datamem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITS)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy)
  );

  datamem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: legal words are a flat array; illegal accesses touch nothing.
  task automatic model_access(input logic m_we, input logic [31:0] m_addr, input logic [31:0] m_wdata,
                              input logic [3:0] m_be, output logic m_err, output logic [31:0] m_rdata);
    int w;
    logic [31:0] word;
    w = int'(m_addr / 4);
    m_rdata = 32'd0;
    if ((m_addr % 4) != 0 || m_addr >= 32'(4 * DEPTH)) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      word = mm.exists(w) ? mm[w] : 32'd0;
      if (m_we) begin
`ifdef DATAMEM_BYTE_EN
        for (int i = 0; i < 4; i++)
          if (m_be[i]) word[8*i +: 8] = m_wdata[8*i +: 8];
`else
        word = m_wdata;
`endif
        mm[w] = word;
      end else begin
        m_rdata = word;
      end
    end
  endtask

  // One transaction on the WAITS dut; inputs are scrambled right after accept.
  task automatic do_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [3:0] t_be, input bit drop_req,
                        output logic o_err, output logic [31:0] o_rdata);
    int k;
    int busy_cnt;
    bit seen;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    seen = 1'b0; busy_cnt = 0; k = 0;
    o_err = 1'b0; o_rdata = 32'd0;
    while (!seen && k < WAITS + 6) begin
      @(posedge clk); #1;
      k++;
      if (busy) busy_cnt++;
      if (k == 1) begin
        addr = $urandom; wdata = $urandom; we = ~t_we; be = ~t_be;
        if (drop_req) req = 1'b0;
      end
      if (ack) begin
        seen = 1'b1;
        o_err = err;
        o_rdata = rdata;
        chk("ack_latency", 32'(k), 32'(WAITS + 1));
        req = 1'b0;
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk("ack_single_pulse", 32'(ack), 32'd0);
    chk("busy_after_ack", 32'(busy), 32'd0);
    chk("busy_cycles", 32'(busy_cnt), 32'(WAITS + 1));
    we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic        g_err, m_err;
    logic [31:0] g_rd, m_rd;
    logic [31:0] v_ld20, v_ld10;
    logic [31:0] d0 [6];
    logic [31:0] a0 [6];
    int t;
    bit prev_ack;

`ifdef DATAMEM_BYTE_EN
    v_ld20 = 32'hAA22CC44;
    v_ld10 = 32'hDEADBEEF;
`else
    v_ld20 = 32'h11223344;
    v_ld10 = 32'h00000000;
`endif
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h20,   32'h11223344, 4'h5, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 1'b0, v_ld20};
    vecs[5]  = '{1'b0, 32'h13,   32'h0,        4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h1000, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h1000, 32'h55555555, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,    32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 32'h10,   32'h0,        4'h0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h10,   32'h0,        4'hF, 1'b0, v_ld10};
    vecs[12] = '{1'b1, 32'h40,   32'h0BADF00D, 4'hF, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'hFFC,  32'h0F0F0F0F, 4'hF, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'hFFC,  32'h0,        4'hF, 1'b0, 32'h0F0F0F0F};
    vecs[15] = '{1'b0, 32'h40,   32'h0,        4'hF, 1'b0, 32'h0BADF00D};

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, (i % 2) == 1, g_err, g_rd);
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, m_err, m_rd);
      chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rdata);
    end

    // Reset while a store sits in WAIT: outputs clear at once, store is lost.
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h12345678; be = 4'hF;
    @(posedge clk); #1;
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    req = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b0, 32'h40, 32'h0, 4'hF, 1'b0, g_err, g_rd);
    chk("rst_mid_readback", g_rd, 32'h0BADF00D);
    chk("rst_mid_readback_err", 32'(g_err), 32'd0);

    // Zero wait states, req held high: 3 stores then 3 loads, ack every 2nd cycle.
    for (int i = 0; i < 3; i++) begin
      a0[i] = 32'h100 + 32'(i * 4);
      d0[i] = $urandom;
      a0[i+3] = a0[i];
      d0[i+3] = 32'h0;
    end
    t = 0; prev_ack = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = a0[0]; wdata0 = d0[0];
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("z_ack_c%0d", k), 32'(ack0), 32'(k % 2));
      chk("z_no_double_ack", 32'(prev_ack && ack0), 32'd0);
      prev_ack = ack0;
      if (ack0 && t < 6) begin
        chk($sformatf("z_rdata_t%0d", t), rdata0, (t >= 3) ? d0[t-3] : 32'd0);
        chk("z_err", 32'(err0), 32'd0);
        t++;
        if (t < 6) begin
          we0 = (t < 3); addr0 = a0[t]; wdata0 = (t < 3) ? d0[t] : 32'($urandom);
        end else begin
          req0 = 1'b0;
        end
      end
    end
    req0 = 1'b0;

    // Randomized traffic against the reference model.
    for (int w = 0; w < 64; w++) begin
      do_txn(1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0, g_err, g_rd);
      model_access(1'b1, 32'(w * 4), wdata, 4'hF, m_err, m_rd);
    end
    do_txn(1'b1, 32'hFFC, 32'h0, 4'hF, 1'b0, g_err, g_rd);
    model_access(1'b1, 32'hFFC, 32'h0, 4'hF, m_err, m_rd);
    // Preload data came from $urandom inside do_txn's args; re-sync by reading back via model-driven stores.
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      do_txn(1'b1, 32'(w * 4), d, 4'hF, 1'b0, g_err, g_rd);
      model_access(1'b1, 32'(w * 4), d, 4'hF, m_err, m_rd);
    end

    for (int n = 0; n < 150; n++) begin
      logic        r_we_v;
      logic [31:0] r_addr_v, r_wdata_v;
      logic [3:0]  r_be_v;
      int sel;
      sel = int'($urandom_range(0, 99));
      r_we_v = 1'($urandom_range(0, 1));
      r_wdata_v = $urandom;
      r_be_v = 4'($urandom_range(0, 15));
      if (sel < 75)      r_addr_v = 32'($urandom_range(0, 63)) * 4;
      else if (sel < 82) r_addr_v = 32'hFFC;
      else if (sel < 91) r_addr_v = (32'($urandom_range(0, 63)) * 4) | 32'($urandom_range(1, 3));
      else               r_addr_v = $urandom | 32'h1000;
      do_txn(r_we_v, r_addr_v, r_wdata_v, r_be_v, sel[0], g_err, g_rd);
      model_access(r_we_v, r_addr_v, r_wdata_v, r_be_v, m_err, m_rd);
      chk($sformatf("rand%0d_err", n), 32'(g_err), 32'(m_err));
      chk($sformatf("rand%0d_rdata", n), g_rd, m_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
